// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding,
// default data width and watchdog counter width.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int DefDw = 8;
  localparam int WdW   = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first ReqValid bit above Ptr.
// Ports: ReqValid, Ptr in; one-hot Sel and Found out.
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] ReqValid,
  input  logic [PW-1:0]   Ptr,
  output logic [NREQ-1:0] Sel,
  output logic            Found
);

  logic [PW-1:0] idx;

  // Search starts one past Ptr so the last owner goes to the back.
  always_comb begin
    Sel   = '0;
    Found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(Ptr) + i) % NREQ);
      if (!Found && ReqValid[idx]) begin
        Sel[idx] = 1'b1;
        Found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART transmitter with burst lock and watchdog.
// Ports: Req* requester side, Tx* transmitter side, Grant/Busy/TimeoutErr status.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DW          = DefDw,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [NREQ-1:0]  ReqValid,
  input  logic [NREQ-1:0]  ReqLast,
  input  logic [NREQ*DW-1:0] ReqData,
  output logic [NREQ-1:0]  ReqReady,
  output logic [DW-1:0]    TxData,
  output logic             TxStart,
  input  logic             TxDone,
  output logic [NREQ-1:0]  Grant,
  output logic             Busy,
  output logic             TimeoutErr,
  input  logic             ErrClr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYC - 1);

  state_t state, nextState;

  logic [PW-1:0]   ptr, owner, selIdx;
  logic [NREQ-1:0] sel;
  logic            found;
  logic            last;
  logic [WdW-1:0]  wdCnt;
  logic            wdAtLimit;
  logic            pickLoad, holdLoad;
  logic            freeBus, wdInc, wdFire;
  logic [DW-1:0]   selData, ownerData;

  uart_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .ReqValid (ReqValid),
    .Ptr      (ptr),
    .Sel      (sel),
    .Found    (found)
  );

  always_comb begin
    selIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) selIdx = PW'(i);
    end
  end

  assign selData   = ReqData[int'(selIdx)*DW +: DW];
  assign ownerData = ReqData[int'(owner)*DW +: DW];
  assign wdAtLimit = (wdCnt == WdLimit);
  assign Busy      = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // A finishing byte wins over a watchdog expiring in the same cycle.
  always_comb begin
    nextState = state;
    pickLoad  = 1'b0;
    holdLoad  = 1'b0;
    freeBus   = 1'b0;
    wdInc     = 1'b0;
    wdFire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          pickLoad  = 1'b1;
          nextState = LOAD;
        end
      end
      LOAD: nextState = BUSY;
      BUSY: begin
        wdInc = 1'b1;
        if (TxDone) begin
          if (last) begin
            freeBus   = 1'b1;
            nextState = IDLE;
          end else begin
            nextState = HOLD;
          end
        end else if (wdAtLimit) begin
          wdFire    = 1'b1;
          freeBus   = 1'b1;
          nextState = IDLE;
        end
      end
      HOLD: begin
        wdInc = 1'b1;
        if (|(ReqValid & Grant)) begin
          holdLoad  = 1'b1;
          nextState = LOAD;
        end else if (wdAtLimit) begin
          wdFire    = 1'b1;
          freeBus   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr        <= PW'(NREQ - 1);
      owner      <= '0;
      Grant      <= '0;
      TxData     <= '0;
      last       <= 1'b0;
      TxStart    <= 1'b0;
      ReqReady   <= '0;
      wdCnt      <= '0;
      TimeoutErr <= 1'b0;
    end else begin
      TxStart  <= pickLoad | holdLoad;
      ReqReady <= pickLoad ? sel : (holdLoad ? Grant : '0);
      if (pickLoad) begin
        Grant  <= sel;
        owner  <= selIdx;
        TxData <= selData;
        last   <= ReqLast[selIdx];
      end
      if (holdLoad) begin
        TxData <= ownerData;
        last   <= ReqLast[owner];
      end
      if (freeBus) begin
        Grant <= '0;
        ptr   <= owner;
      end
      if (pickLoad || holdLoad) wdCnt <= '0;
      else if (wdInc)           wdCnt <= wdCnt + 1'b1;
      if (ErrClr)      TimeoutErr <= 1'b0;
      else if (wdFire) TimeoutErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed/randomized bench for uart_tx_arbiter with a round-robin model.
// Drives requesters and TxDone, checks grants, data, latency, watchdog.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 100;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b0;
  logic [NREQ-1:0] ReqValid = '0;
  logic [NREQ-1:0] ReqLast = '0;
  logic [DW-1:0]   d [NREQ];
  logic [NREQ*DW-1:0] ReqData;
  logic [NREQ-1:0] ReqReady;
  logic [DW-1:0]   TxData;
  logic            TxStart;
  logic            TxDone = 1'b0;
  logic [NREQ-1:0] Grant;
  logic            Busy;
  logic            TimeoutErr;
  logic            ErrClr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCount = 0;
  int expStarts = 0;
  int loadCyc = 0;
  int doneCyc = 0;
  int mPtr = NREQ - 1;

  assign ReqData = {d[3], d[2], d[1], d[0]};

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .ReqValid   (ReqValid),
    .ReqLast    (ReqLast),
    .ReqData    (ReqData),
    .ReqReady   (ReqReady),
    .TxData     (TxData),
    .TxStart    (TxStart),
    .TxDone     (TxDone),
    .Grant      (Grant),
    .Busy       (Busy),
    .TimeoutErr (TimeoutErr),
    .ErrClr     (ErrClr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (TxStart === 1'b1) startCount <= startCount + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  // Reference round-robin: first valid requester after the last owner.
  function automatic int refPick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectStart(input string tag, input int idx,
                             input int expCyc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge Clk);
      if (TxStart === 1'b1) seen = 1'b1;
    end
    check({tag, ".seen"}, 32'(seen), 32'd1);
    if (seen) begin
      expStarts++;
      loadCyc = cyc;
      check({tag, ".grant"}, 32'(Grant), 32'(1) << idx);
      check({tag, ".data"}, 32'(TxData), 32'(d[idx]));
      check({tag, ".ready"}, 32'(ReqReady), 32'(1) << idx);
      if (expCyc >= 0) check({tag, ".cyc"}, cyc, expCyc);
    end
  endtask

  task automatic pulseDone(input int delay);
    repeat (delay) @(posedge Clk);
    #1 TxDone = 1'b1;
    doneCyc = cyc;
    @(posedge Clk);
    #1 TxDone = 1'b0;
  endtask

  task automatic waitErr(input string tag, input int expCyc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge Clk);
      if (TimeoutErr === 1'b1) seen = 1'b1;
    end
    check({tag, ".seen"}, 32'(seen), 32'd1);
    check({tag, ".cyc"}, cyc, expCyc);
    check({tag, ".grant"}, 32'(Grant), 32'd0);
    check({tag, ".busy"}, 32'(Busy), 32'd0);
  endtask

  task automatic clearErr();
    @(posedge Clk);
    #1 ErrClr = 1'b1;
    @(posedge Clk);
    #1 ErrClr = 1'b0;
    @(negedge Clk);
    check("errclr", 32'(TimeoutErr), 32'd0);
  endtask

  initial begin
    int exp;
    int n0;
    int r;
    for (int i = 0; i < NREQ; i++) d[i] = '0;

    // Reset state
    @(negedge Clk);
    check("rst.grant", 32'(Grant), 32'd0);
    check("rst.start", 32'(TxStart), 32'd0);
    check("rst.ready", 32'(ReqReady), 32'd0);
    check("rst.data", 32'(TxData), 32'd0);
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.err", 32'(TimeoutErr), 32'd0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Round robin with every requester valid, single-byte messages
    @(posedge Clk);
    #1;
    for (int i = 0; i < NREQ; i++) d[i] = 8'(32'hA0 + i);
    ReqLast  = '1;
    ReqValid = '1;
    n0 = cyc + 1;
    for (int t = 0; t < 5; t++) begin
      exp = refPick(mPtr, ReqValid);
      expectStart("rr", exp, n0);
      @(posedge Clk);
      #1 d[exp] = 8'($urandom);
      if (t == 4) ReqValid = '0;
      pulseDone(19);
      mPtr = exp;
      n0 = doneCyc + 2;
    end
    @(negedge Clk);
    check("rr.idle", 32'(Busy), 32'd0);
    check("rr.gnt0", 32'(Grant), 32'd0);

    // Locked 3-byte burst from requester 2 while requester 0 waits
    @(posedge Clk);
    #1;
    d[0] = 8'($urandom);
    d[2] = 8'h11;
    ReqLast = 4'b0001;
    ReqValid = 4'b0101;
    exp = refPick(mPtr, ReqValid);
    expectStart("burst1", exp, cyc + 1);
    @(posedge Clk);
    #1 d[2] = 8'h22;
    pulseDone(5);
    expectStart("burst2", 2, doneCyc + 2);
    @(posedge Clk);
    #1 d[2] = 8'h33;
    ReqLast[2] = 1'b1;
    pulseDone(5);
    expectStart("burst3", 2, doneCyc + 2);
    @(posedge Clk);
    #1 ReqValid[2] = 1'b0;
    pulseDone(5);
    mPtr = 2;
    exp = refPick(mPtr, ReqValid);
    expectStart("burstNext", exp, doneCyc + 2);
    @(posedge Clk);
    #1 ReqValid = '0;
    pulseDone(5);
    mPtr = exp;

    // Transmitter never answers: watchdog abandons the byte
    @(posedge Clk);
    #1;
    d[1] = 8'($urandom);
    d[3] = 8'($urandom);
    ReqLast = '1;
    ReqValid = 4'b1010;
    exp = refPick(mPtr, ReqValid);
    expectStart("wd", exp, cyc + 1);
    n0 = loadCyc;
    @(posedge Clk);
    #1 ReqValid[exp] = 1'b0;
    waitErr("wd.err", n0 + 1 + TMO);
    mPtr = exp;
    exp = refPick(mPtr, ReqValid);
    expectStart("wdNext", exp, n0 + 2 + TMO);
    @(posedge Clk);
    #1 ReqValid = '0;
    pulseDone(3);
    mPtr = exp;
    @(negedge Clk);
    check("wd.sticky", 32'(TimeoutErr), 32'd1);
    clearErr();

    // Owner stalls mid-burst: HOLD until the watchdog releases it
    @(posedge Clk);
    #1;
    d[1] = 8'($urandom);
    d[3] = 8'($urandom);
    ReqLast = 4'b1000;
    ReqValid = 4'b1010;
    exp = refPick(mPtr, ReqValid);
    expectStart("stall", exp, cyc + 1);
    n0 = loadCyc;
    @(posedge Clk);
    #1 ReqValid[exp] = 1'b0;
    pulseDone(10);
    while (cyc < n0 + 50) @(negedge Clk);
    check("stall.hold", 32'(Grant), 32'(1) << exp);
    check("stall.busy", 32'(Busy), 32'd1);
    waitErr("stall.err", n0 + 1 + TMO);
    check("stall.starts", startCount, expStarts);
    mPtr = exp;
    exp = refPick(mPtr, ReqValid);
    expectStart("stallNext", exp, n0 + 2 + TMO);
    @(posedge Clk);
    #1 ReqValid = '0;
    pulseDone(3);
    mPtr = exp;
    clearErr();

    // ErrClr held across a watchdog expiry keeps the flag low
    @(posedge Clk);
    #1;
    ErrClr = 1'b1;
    d[0] = 8'($urandom);
    ReqLast = '1;
    ReqValid = 4'b0001;
    exp = refPick(mPtr, ReqValid);
    expectStart("clrPri", exp, cyc + 1);
    n0 = loadCyc;
    @(posedge Clk);
    #1 ReqValid = '0;
    while (cyc < n0 + 1 + TMO) @(negedge Clk);
    check("clrPri.err", 32'(TimeoutErr), 32'd0);
    check("clrPri.busy", 32'(Busy), 32'd0);
    mPtr = exp;
    @(posedge Clk);
    #1 ErrClr = 1'b0;

    // Stray TxDone in IDLE and in LOAD
    @(posedge Clk);
    #1 TxDone = 1'b1;
    @(posedge Clk);
    #1 TxDone = 1'b0;
    @(negedge Clk);
    check("strayIdle.busy", 32'(Busy), 32'd0);
    check("strayIdle.starts", startCount, expStarts);
    @(posedge Clk);
    #1;
    d[0] = 8'($urandom);
    ReqLast = 4'b0000;
    ReqValid = 4'b0001;
    exp = refPick(mPtr, ReqValid);
    expectStart("stray1", exp, cyc + 1);
    TxDone = 1'b1;
    @(posedge Clk);
    #1 TxDone = 1'b0;
    d[0] = 8'($urandom);
    ReqLast[0] = 1'b1;
    repeat (5) @(negedge Clk);
    check("strayLoad.busy", 32'(Busy), 32'd1);
    check("strayLoad.grant", 32'(Grant), 32'd1);
    check("strayLoad.starts", startCount, expStarts);
    pulseDone(2);
    expectStart("stray2", 0, doneCyc + 2);
    @(posedge Clk);
    #1 ReqValid = '0;
    pulseDone(2);
    mPtr = 0;

    // Reset in BUSY, then requester 0 has priority
    @(posedge Clk);
    #1;
    r = $urandom_range(1, 3);
    d[r] = 8'($urandom);
    ReqLast = '1;
    ReqValid = 4'(32'(1) << r);
    expectStart("preRst", refPick(mPtr, ReqValid), cyc + 1);
    @(posedge Clk);
    #1 ReqValid = '0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    check("midRst.busy", 32'(Busy), 32'd0);
    check("midRst.grant", 32'(Grant), 32'd0);
    check("midRst.data", 32'(TxData), 32'd0);
    check("midRst.start", 32'(TxStart), 32'd0);
    @(negedge Clk);
    check("midRst.ready", 32'(ReqReady), 32'd0);
    @(posedge Clk);
    #1;
    for (int i = 0; i < NREQ; i++) d[i] = 8'($urandom);
    ReqValid = 4'($urandom) | 4'b0001;
    Rst_n = 1'b1;
    mPtr = NREQ - 1;
    expectStart("postRst", refPick(mPtr, ReqValid), cyc + 1);
    @(posedge Clk);
    #1 ReqValid = '0;
    pulseDone(2);
    @(negedge Clk);
    check("end.starts", startCount, expStarts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
